axi_mem_master: RTL and testbench
=================================

AXI_MEM_MASTER -- requirements
Module: axi_mem_master

Interface
REQ-001 Parameters (name, default, meaning): AXI_ADDR_WIDTH, 64, address bits; AXI_DATA_WIDTH, 64, data bits; AXI_ID_WIDTH, 4, ID bits; AXI_USER_WIDTH, 4, user bits; MASTER_ID, 0, constant AxID driven on AR/AW.
REQ-002 clk_i  in  1  clock, rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
REQ-005 cmd_write_i  in  1  1=write burst, 0=read burst.
REQ-006 cmd_addr_i  in  AXI_ADDR_WIDTH  start byte address.
REQ-007 cmd_len_i  in  8  beats minus one (AXI len encoding).
REQ-008 wdata_i / wstrb_i  in  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  write beat data and strobes.
REQ-009 wvalid_i / wready_o  in/out  1  write-beat handshake.
REQ-010 rdata_o / rlast_o  out  AXI_DATA_WIDTH / 1  read beat data and last flag.
REQ-011 rvalid_o / rready_i  out/in  1  read-beat handshake.
REQ-012 done_o  out  1  one-cycle pulse on completion of a command.
REQ-013 busy_o  out  1  high whenever state != IDLE.
REQ-014 err_o  out  1  sticky error flag (see Configuration).
REQ-015 axi  AXI_BUS.Master  -  AXI4 master port.

Function
REQ-016 States: IDLE, AR, R, AW, W, B; one transaction outstanding at a time.
REQ-017 cmd_ready_o = 1 only in IDLE; on handshake, addr (low log2(AXI_DATA_WIDTH/8) bits cleared), len and write are registered; next state AR (read) or AW (write).
REQ-018 AR/AW: AxVALID=1, AxADDR/AxLEN from registers, AxSIZE=log2(AXI_DATA_WIDTH/8), AxBURST=INCR, AxID=MASTER_ID, other Ax fields 0; held stable until AxREADY; AR->R, AW->W on handshake.
REQ-019 R: combinational passthrough: rdata_o=r_data, rlast_o=r_last, rvalid_o=r_valid, r_ready=rready_i; on r_valid&&r_ready&&r_last -> IDLE and done_o pulses next cycle.
REQ-020 W: w_valid=wvalid_i, wready_o=w_ready, w_data/w_strb passthrough; 8-bit beat counter increments per W handshake; w_last=(beat_cnt==len); after last handshake counter clears, state -> B.
REQ-021 B: b_ready=1; on b_valid -> IDLE and done_o pulses next cycle.
REQ-022 Outside their states, AR/AW/W valids, r_ready, wready_o and rvalid_o are 0.
REQ-023 len=0 produces a single beat with last asserted on that beat.
REQ-024 Commands crossing a 4 KiB boundary are illegal; a simulation assertion fires on acceptance.
REQ-025 cmd_valid_i asserted while busy is held off (cmd_ready_o=0); no command is dropped.

Reset
REQ-026 On rst_ni low: state IDLE, beat counter 0, registers 0, done_o=0, err_o=0, all AXI valids/readies 0; cmd_ready_o=1 after release.
REQ-027 Reset mid-burst abandons the transaction immediately; no done_o pulse follows.

Configuration
REQ-028 Macro AXI_MEM_MASTER_ERR_EN: when defined, a non-OKAY r_resp or b_resp, or r_last on a beat other than beat len (R beats counted), sets err_o, which stays set until reset; when undefined, responses are ignored, no R beat counter is built, err_o tied 0.

Verification
REQ-029 Read cmd addr=0x1000 len=3, slave returns D0..D3 -> one AR (len=3,size=3,INCR), four rvalid_o beats, rlast_o on 4th, done_o one pulse.
REQ-030 Write cmd addr=0x2008 len=1, beats 0xAA/0xBB strb=0xFF -> AW then 2 W beats, w_last on 2nd, b handshake, done_o pulse.
REQ-031 rready_i low for 5 cycles mid-read -> r_ready low, no beats lost, data order preserved.
REQ-032 Back-to-back cmd while busy -> cmd_ready_o=0 until IDLE, second command issued after done_o.
REQ-033 With AXI_MEM_MASTER_ERR_EN, b_resp=SLVERR -> err_o=1 and holds; without macro err_o stays 0.
REQ-034 Reset asserted during W beat 2 of len=7 -> all AXI valids 0 same cycle, state IDLE, no done_o.

Source files
------------

// File: rtl/axi_mem_master_if.sv
// AXI4 bus bundle shared by axi_mem_master and its slave.
// Master drives addresses, write data and response readies.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_mem_master.sv
// Single-outstanding AXI4 burst master: one read or write INCR burst per command.
// Optional AXI_MEM_MASTER_ERR_EN adds sticky response/last-beat error detection on err_o.
module axi_mem_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned MASTER_ID      = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [7:0]                  cmd_len_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                        wvalid_i,
    output logic                        wready_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        rlast_o,
    output logic                        rvalid_o,
    input  logic                        rready_i,
    output logic                        done_o,
    output logic                        busy_o,
    output logic                        err_o,
    AXI_BUS.Master                      axi
);

    localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam logic [2:0]  AX_SIZE  = 3'(ADDR_LSB);
    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = ~(AXI_ADDR_WIDTH'(STRB_W - 1));

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_e;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [7:0]                beat_q;
    logic                      ar_valid_q;
    logic                      aw_valid_q;
    logic                      b_ready_q;
    logic                      done_q;

    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_aligned;
    logic                      in_r, in_w;
    logic                      r_hs, w_hs, w_last;

    assign cmd_addr_aligned = cmd_addr_i & ADDR_MASK;
    assign in_r   = (state_q == R);
    assign in_w   = (state_q == W);
    assign r_hs   = in_r && axi.r_valid && rready_i;
    assign w_hs   = in_w && wvalid_i && axi.w_ready;
    assign w_last = (beat_q == len_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            b_ready_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q <= cmd_addr_aligned;
                        len_q  <= cmd_len_i;
                        if (cmd_write_i) begin
                            state_q    <= AW;
                            aw_valid_q <= 1'b1;
                        end else begin
                            state_q    <= AR;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (axi.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= R;
                    end
                end
                R: begin
                    if (r_hs && axi.r_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                AW: begin
                    if (axi.aw_ready) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        if (w_last) begin
                            beat_q    <= '0;
                            b_ready_q <= 1'b1;
                            state_q   <= B;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                B: begin
                    if (axi.b_valid) begin
                        b_ready_q <= 1'b0;
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    assign axi.ar_valid  = ar_valid_q;
    assign axi.ar_addr   = addr_q;
    assign axi.ar_len    = len_q;
    assign axi.ar_size   = AX_SIZE;
    assign axi.ar_burst  = BURST_INCR;
    assign axi.ar_id     = AXI_ID_WIDTH'(MASTER_ID);
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = '0;
    assign axi.ar_prot   = '0;
    assign axi.ar_qos    = '0;
    assign axi.ar_region = '0;
    assign axi.ar_user   = '0;

    assign axi.aw_valid  = aw_valid_q;
    assign axi.aw_addr   = addr_q;
    assign axi.aw_len    = len_q;
    assign axi.aw_size   = AX_SIZE;
    assign axi.aw_burst  = BURST_INCR;
    assign axi.aw_id     = AXI_ID_WIDTH'(MASTER_ID);
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = '0;
    assign axi.aw_prot   = '0;
    assign axi.aw_qos    = '0;
    assign axi.aw_region = '0;
    assign axi.aw_user   = '0;

    // Data beats pass straight through; only the handshake qualifiers are gated by state.
    assign axi.w_valid = in_w && wvalid_i;
    assign axi.w_data  = wdata_i;
    assign axi.w_strb  = wstrb_i;
    assign axi.w_last  = in_w && w_last;
    assign axi.w_user  = '0;
    assign wready_o    = in_w && axi.w_ready;

    assign axi.b_ready = b_ready_q;

    assign rdata_o     = axi.r_data;
    assign rlast_o     = in_r && axi.r_last;
    assign rvalid_o    = in_r && axi.r_valid;
    assign axi.r_ready = in_r && rready_i;

`ifdef AXI_MEM_MASTER_ERR_EN
    logic [7:0] rbeat_q;
    logic       err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rbeat_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (r_hs) begin
                rbeat_q <= axi.r_last ? 8'd0 : rbeat_q + 8'd1;
                if ((axi.r_resp != 2'b00) || (axi.r_last && (rbeat_q != len_q)))
                    err_q <= 1'b1;
            end
            if ((state_q == B) && axi.b_valid && (axi.b_resp != 2'b00))
                err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    logic unused_ok;
    assign unused_ok = ^{axi.b_id, axi.b_user, axi.r_id, axi.r_user};
`else
    assign err_o = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{axi.b_id, axi.b_user, axi.b_resp, axi.r_id, axi.r_user, axi.r_resp};
`endif

`ifndef SYNTHESIS
    // A burst must end at or before the next 4 KiB page start.
    logic [23:0] burst_end;
    assign burst_end = 24'(cmd_addr_aligned[11:0]) + ((24'(cmd_len_i) + 24'd1) << ADDR_LSB);

    always_ff @(posedge clk_i) begin
        if (rst_ni && cmd_valid_i && cmd_ready_o)
            assert (burst_end <= 24'd4096);
    end
`endif

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master: table of bursts plus hand-written corner sequences.
module tb_axi_mem_master;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned IW  = 4;
    localparam int unsigned UW  = 4;
    localparam int unsigned MID = 5;
`ifdef AXI_MEM_MASTER_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [7:0]    cmd_len_i;
    logic [DW-1:0] wdata_i;
    logic [DW/8-1:0] wstrb_i;
    logic          wvalid_i, wready_o;
    logic [DW-1:0] rdata_o;
    logic          rlast_o, rvalid_o, rready_i;
    logic          done_o, busy_o, err_o;

    AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
              .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) axi_if ();

    axi_mem_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
        .AXI_USER_WIDTH(UW), .MASTER_ID(MID)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .axi(axi_if)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [63:0] exp_addr;
        logic [63:0] dbase;
        logic [7:0]  strb;
        int          stall_at;
        int          stall_len;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        cmd_valid_i = 1'b1; cmd_write_i = v.wr; cmd_addr_i = v.addr; cmd_len_i = v.len;
        settle();
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cyc();
        cmd_valid_i = 1'b0;
        settle();
        chk("busy_after_accept", busy_o, 1);
        chk("cmd_ready_busy", cmd_ready_o, 0);
        if (!v.wr) begin
            chk("ar_valid", axi_if.ar_valid, 1);
            chk("ar_addr", axi_if.ar_addr, v.exp_addr);
            chk("ar_len", axi_if.ar_len, v.len);
            chk("ar_size", axi_if.ar_size, 3);
            chk("ar_burst", axi_if.ar_burst, 1);
            chk("ar_id", axi_if.ar_id, MID);
            chk("aw_valid_in_ar", axi_if.aw_valid, 0);
            cyc(); settle();
            chk("ar_hold_valid", axi_if.ar_valid, 1);
            chk("ar_hold_addr", axi_if.ar_addr, v.exp_addr);
            axi_if.ar_ready = 1'b1;
            cyc();
            axi_if.ar_ready = 1'b0;
            settle();
            chk("ar_drop", axi_if.ar_valid, 0);
            for (int i = 0; i <= int'(v.len); i++) begin
                if (i == v.stall_at) begin
                    for (int s = 0; s < v.stall_len; s++) begin
                        axi_if.r_valid = 1'b1; axi_if.r_data = v.dbase + 64'(i);
                        axi_if.r_last = (i == int'(v.len)); rready_i = 1'b0;
                        settle();
                        chk("r_ready_stall", axi_if.r_ready, 0);
                        chk("rvalid_stall", rvalid_o, 1);
                        cyc();
                    end
                end
                axi_if.r_valid = 1'b1; axi_if.r_data = v.dbase + 64'(i);
                axi_if.r_last = (i == int'(v.len)); rready_i = 1'b1;
                settle();
                chk("rvalid_o", rvalid_o, 1);
                chk("rdata_o", rdata_o, v.dbase + 64'(i));
                chk("rlast_o", rlast_o, (i == int'(v.len)));
                chk("r_ready", axi_if.r_ready, 1);
                chk("done_mid_read", done_o, 0);
                cyc();
            end
            axi_if.r_valid = 1'b0; axi_if.r_last = 1'b0; rready_i = 1'b0;
            settle();
            chk("read_done_pulse", done_o, 1);
            chk("read_idle", busy_o, 0);
            chk("rvalid_idle", rvalid_o, 0);
        end else begin
            wvalid_i = 1'b1; axi_if.w_ready = 1'b1;
            settle();
            chk("aw_valid", axi_if.aw_valid, 1);
            chk("aw_addr", axi_if.aw_addr, v.exp_addr);
            chk("aw_len", axi_if.aw_len, v.len);
            chk("aw_size", axi_if.aw_size, 3);
            chk("aw_burst", axi_if.aw_burst, 1);
            chk("aw_id", axi_if.aw_id, MID);
            chk("ar_valid_in_aw", axi_if.ar_valid, 0);
            chk("w_valid_in_aw", axi_if.w_valid, 0);
            chk("wready_in_aw", wready_o, 0);
            axi_if.aw_ready = 1'b1;
            cyc();
            axi_if.aw_ready = 1'b0;
            for (int i = 0; i <= int'(v.len); i++) begin
                wvalid_i = 1'b1; wdata_i = v.dbase + 64'(i) * 64'h11; wstrb_i = v.strb;
                axi_if.w_ready = 1'b1;
                settle();
                chk("w_valid", axi_if.w_valid, 1);
                chk("w_data", axi_if.w_data, v.dbase + 64'(i) * 64'h11);
                chk("w_strb", axi_if.w_strb, v.strb);
                chk("w_last", axi_if.w_last, (i == int'(v.len)));
                chk("wready_o", wready_o, 1);
                cyc();
            end
            wvalid_i = 1'b0; axi_if.w_ready = 1'b0;
            settle();
            chk("b_ready", axi_if.b_ready, 1);
            chk("w_valid_in_b", axi_if.w_valid, 0);
            chk("done_in_b", done_o, 0);
            axi_if.b_valid = 1'b1; axi_if.b_resp = 2'b00;
            cyc();
            axi_if.b_valid = 1'b0;
            settle();
            chk("write_done_pulse", done_o, 1);
            chk("write_idle", busy_o, 0);
            chk("b_ready_idle", axi_if.b_ready, 0);
        end
        cyc(); settle();
        chk("done_one_cycle", done_o, 0);
    endtask

    initial begin
        vecs[0] = '{wr: 1'b0, addr: 64'h1000, len: 8'd3, exp_addr: 64'h1000, dbase: 64'hD0,
                    strb: 8'h00, stall_at: -1, stall_len: 0};
        vecs[1] = '{wr: 1'b1, addr: 64'h2008, len: 8'd1, exp_addr: 64'h2008, dbase: 64'hAA,
                    strb: 8'hFF, stall_at: -1, stall_len: 0};
        vecs[2] = '{wr: 1'b0, addr: 64'h3005, len: 8'd0, exp_addr: 64'h3000, dbase: 64'h5A5A,
                    strb: 8'h00, stall_at: -1, stall_len: 0};
        vecs[3] = '{wr: 1'b1, addr: 64'h400F, len: 8'd0, exp_addr: 64'h4008, dbase: 64'h1234,
                    strb: 8'h0F, stall_at: -1, stall_len: 0};
        vecs[4] = '{wr: 1'b0, addr: 64'h5000, len: 8'd4, exp_addr: 64'h5000, dbase: 64'hC0,
                    strb: 8'h00, stall_at: 2, stall_len: 5};
        vecs[5] = '{wr: 1'b1, addr: 64'h6010, len: 8'd3, exp_addr: 64'h6010, dbase: 64'h100,
                    strb: 8'hF0, stall_at: -1, stall_len: 0};

        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; rready_i = 1'b0;
        axi_if.aw_ready = 1'b0; axi_if.w_ready = 1'b0; axi_if.ar_ready = 1'b0;
        axi_if.b_valid = 1'b0; axi_if.b_resp = 2'b00; axi_if.b_id = '0; axi_if.b_user = '0;
        axi_if.r_valid = 1'b0; axi_if.r_data = '0; axi_if.r_last = 1'b0; axi_if.r_resp = 2'b00;
        axi_if.r_id = '0; axi_if.r_user = '0;

        cyc(); cyc(); settle();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ar_valid", axi_if.ar_valid, 0);
        chk("rst_aw_valid", axi_if.aw_valid, 0);
        chk("rst_b_ready", axi_if.b_ready, 0);
        cyc();
        rst_ni = 1'b1;
        settle();
        chk("rst_release_cmd_ready", cmd_ready_o, 1);
        cyc();

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // Second command held on cmd_valid_i while the first read is in flight.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 64'h7000; cmd_len_i = 8'd0;
        settle();
        chk("b2b_ready_first", cmd_ready_o, 1);
        cyc();
        cmd_write_i = 1'b1; cmd_addr_i = 64'h8000; cmd_len_i = 8'd0;
        settle();
        chk("b2b_ar_valid", axi_if.ar_valid, 1);
        chk("b2b_ready_in_ar", cmd_ready_o, 0);
        chk("b2b_no_aw", axi_if.aw_valid, 0);
        axi_if.ar_ready = 1'b1;
        cyc();
        axi_if.ar_ready = 1'b0;
        settle();
        chk("b2b_ready_in_r", cmd_ready_o, 0);
        axi_if.r_valid = 1'b1; axi_if.r_data = 64'h77; axi_if.r_last = 1'b1; rready_i = 1'b1;
        settle();
        chk("b2b_rdata", rdata_o, 64'h77);
        cyc();
        axi_if.r_valid = 1'b0; axi_if.r_last = 1'b0; rready_i = 1'b0;
        settle();
        chk("b2b_done_first", done_o, 1);
        chk("b2b_ready_after_done", cmd_ready_o, 1);
        cyc();
        cmd_valid_i = 1'b0;
        settle();
        chk("b2b_aw_valid", axi_if.aw_valid, 1);
        chk("b2b_aw_addr", axi_if.aw_addr, 64'h8000);
        chk("b2b_done_cleared", done_o, 0);
        axi_if.aw_ready = 1'b1;
        cyc();
        axi_if.aw_ready = 1'b0;
        wvalid_i = 1'b1; wdata_i = 64'h88; wstrb_i = 8'hFF; axi_if.w_ready = 1'b1;
        settle();
        chk("b2b_w_last", axi_if.w_last, 1);
        cyc();
        wvalid_i = 1'b0; axi_if.w_ready = 1'b0; axi_if.b_valid = 1'b1;
        cyc();
        axi_if.b_valid = 1'b0;
        settle();
        chk("b2b_done_second", done_o, 1);
        cyc();

        // Reset lands while beat 2 of an 8-beat write is on the bus.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 64'h9000; cmd_len_i = 8'd7;
        cyc();
        cmd_valid_i = 1'b0; axi_if.aw_ready = 1'b1;
        cyc();
        axi_if.aw_ready = 1'b0;
        wvalid_i = 1'b1; axi_if.w_ready = 1'b1; wstrb_i = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            wdata_i = 64'(i);
            cyc();
        end
        wdata_i = 64'd2;
        settle();
        chk("rstmid_w_valid_before", axi_if.w_valid, 1);
        chk("rstmid_w_last_before", axi_if.w_last, 0);
        rst_ni = 1'b0;
        settle();
        chk("rstmid_w_valid", axi_if.w_valid, 0);
        chk("rstmid_wready", wready_o, 0);
        chk("rstmid_aw_valid", axi_if.aw_valid, 0);
        chk("rstmid_ar_valid", axi_if.ar_valid, 0);
        chk("rstmid_b_ready", axi_if.b_ready, 0);
        chk("rstmid_busy", busy_o, 0);
        wvalid_i = 1'b0; axi_if.w_ready = 1'b0;
        cyc(); cyc();
        rst_ni = 1'b1;
        settle();
        chk("rstmid_no_done", done_o, 0);
        chk("rstmid_cmd_ready", cmd_ready_o, 1);
        cyc(); settle();
        chk("rstmid_no_done_late", done_o, 0);
        run_vec('{wr: 1'b1, addr: 64'hA000, len: 8'd1, exp_addr: 64'hA000, dbase: 64'h40,
                  strb: 8'hFF, stall_at: -1, stall_len: 0});

        // Error response: sticky when detection is built, ignored otherwise.
        chk("err_clear_before", err_o, 0);
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 64'hB000; cmd_len_i = 8'd0;
        cyc();
        cmd_valid_i = 1'b0; axi_if.aw_ready = 1'b1;
        cyc();
        axi_if.aw_ready = 1'b0; wvalid_i = 1'b1; axi_if.w_ready = 1'b1;
        cyc();
        wvalid_i = 1'b0; axi_if.w_ready = 1'b0;
        axi_if.b_valid = 1'b1; axi_if.b_resp = 2'b10;
        cyc();
        axi_if.b_valid = 1'b0; axi_if.b_resp = 2'b00;
        settle();
        chk("err_slverr", err_o, ERR_EXP);
        chk("err_done", done_o, 1);
        cyc(); cyc(); cyc(); settle();
        chk("err_sticky", err_o, ERR_EXP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
